// File: rtl/fft_mag_streamer_pkg.sv
// Shared constants and types for the FFT squared-magnitude streamer.
package fft_pkg;

  localparam int NSAMPLES = 1024;
  localparam int DW       = 16;
  localparam int MAG_W    = 2 * DW + 1;
  localparam int NBITS    = $clog2(NSAMPLES);

  typedef logic [MAG_W-1:0]     mag_t;
  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {FILL, FLUSH, DRAIN} state_t;

endpackage

// File: rtl/fft_mag_streamer_if.sv
// Valid/ready stream of complex FFT bins feeding the magnitude streamer.
interface fft_mag_streamer_if import fft_pkg::*; ();

  sample_t fft_re;
  sample_t fft_im;
  logic    fft_valid;
  logic    fft_last;
  logic    fft_ready;

  modport master (output fft_re, fft_im, fft_valid, fft_last, input fft_ready);
  modport slave  (input fft_re, fft_im, fft_valid, fft_last, output fft_ready);

endinterface

// File: rtl/fft_mag_streamer_mag_sq.sv
// Two-stage squared-magnitude pipeline: squares, then unsigned sum.
// The buffer address travels alongside the data as a sideband.
module fft_mag_sq import fft_pkg::*; (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  sample_t          re,
  input  sample_t          im,
  input  logic [NBITS-1:0] in_addr,
  output logic             out_valid,
  output mag_t             out_mag,
  output logic [NBITS-1:0] out_addr,
  output logic             busy
);

  logic signed [2*DW-1:0] sq_re_reg, sq_im_reg;
  logic                   s1_valid_reg, s2_valid_reg;
  logic [NBITS-1:0]       s1_addr_reg, s2_addr_reg;
  mag_t                   s2_mag_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      sq_re_reg    <= '0;
      sq_im_reg    <= '0;
      s1_addr_reg  <= '0;
      s2_addr_reg  <= '0;
      s2_mag_reg   <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      sq_re_reg    <= (2*DW)'(re) * (2*DW)'(re);
      sq_im_reg    <= (2*DW)'(im) * (2*DW)'(im);
      s1_addr_reg  <= in_addr;
      s2_valid_reg <= s1_valid_reg;
      // Squares are non-negative, so zero-extension gives the exact sum.
      s2_mag_reg   <= MAG_W'($unsigned(sq_re_reg)) + MAG_W'($unsigned(sq_im_reg));
      s2_addr_reg  <= s1_addr_reg;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_mag   = s2_mag_reg;
  assign out_addr  = s2_addr_reg;
  assign busy      = s1_valid_reg | s2_valid_reg;

endmodule

// File: rtl/fft_mag_streamer.sv
// Buffers one FFT frame of |X|^2 and replays it as a gap-free stream.
// Optional macro FFT_MAG_NEG_BLANK_EN zeroes odd arrival indices (negative bins).
module fft_mag_streamer import fft_pkg::*; (
  input  logic                clk,
  input  logic                reset_n,
  fft_mag_streamer_if.slave   fft,
  output mag_t                mag,
  output logic                mag_valid,
  output logic                frame_err
);

  state_t           state_reg, state_next;
  logic [NBITS-1:0] acc_cnt_reg, acc_cnt_next;
  logic [NBITS-1:0] rd_cnt_reg, rd_cnt_next;
  logic             fft_ready_reg, mag_valid_reg, frame_err_reg, frame_err_next;
  mag_t             mag_reg;
  mag_t             buffer [NSAMPLES];

  logic             accept, frame_full;
  logic             sq_valid, pipe_busy;
  mag_t             sq_mag, wr_data;
  logic [NBITS-1:0] sq_addr;

  assign accept     = fft.fft_valid && fft_ready_reg && (state_reg == FILL);
  assign frame_full = (acc_cnt_reg == NBITS'(NSAMPLES - 1));

  fft_mag_sq u_mag_sq (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (accept),
    .re       (fft.fft_re),
    .im       (fft.fft_im),
    .in_addr  (acc_cnt_reg),
    .out_valid(sq_valid),
    .out_mag  (sq_mag),
    .out_addr (sq_addr),
    .busy     (pipe_busy)
  );

`ifdef FFT_MAG_NEG_BLANK_EN
  assign wr_data = sq_addr[0] ? '0 : sq_mag;
`else
  assign wr_data = sq_mag;
`endif

  always_comb begin
    state_next     = state_reg;
    acc_cnt_next   = acc_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    frame_err_next = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (fft.fft_last && frame_full) begin
            acc_cnt_next = '0;
            state_next   = FLUSH;
          end else if (fft.fft_last || frame_full) begin
            acc_cnt_next   = '0;
            frame_err_next = 1'b1;
          end else begin
            acc_cnt_next = acc_cnt_reg + NBITS'(1);
          end
        end
      end
      FLUSH: begin
        // Every accepted bin has reached the buffer once the pipeline is empty.
        if (!pipe_busy) begin
          rd_cnt_next = '0;
          state_next  = DRAIN;
        end
      end
      DRAIN: begin
        rd_cnt_next = rd_cnt_reg + NBITS'(1);
        if (rd_cnt_reg == NBITS'(NSAMPLES - 1)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= FILL;
      acc_cnt_reg   <= '0;
      rd_cnt_reg    <= '0;
      fft_ready_reg <= 1'b0;
      mag_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_cnt_reg   <= acc_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      fft_ready_reg <= (state_next == FILL);
      mag_valid_reg <= (state_reg == DRAIN);
      frame_err_reg <= frame_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (sq_valid) buffer[sq_addr] <= wr_data;
  end

  // Registered RAM read doubles as the output register; forced to 0 when idle.
  always_ff @(posedge clk) begin
    if (!reset_n)                mag_reg <= '0;
    else if (state_reg == DRAIN) mag_reg <= buffer[rd_cnt_reg];
    else                         mag_reg <= '0;
  end

  assign fft.fft_ready = fft_ready_reg;
  assign mag           = mag_reg;
  assign mag_valid     = mag_valid_reg;
  assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_fft_mag_streamer.sv
// Randomized frame-level bench for fft_mag_streamer with a behavioural |X|^2 model.
module tb_fft_mag_streamer;
  import fft_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   reset_n;
  mag_t   mag;
  logic   mag_valid, frame_err;
  fft_mag_streamer_if bus ();

  fft_mag_streamer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .fft      (bus.slave),
    .mag      (mag),
    .mag_valid(mag_valid),
    .frame_err(frame_err)
  );

  int     errors = 0;
  int     checks = 0;
  int     err_cycles = 0;
  int     mv_cycles = 0;
  longint exp_mag [NSAMPLES];

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (mag_valid) mv_cycles++;
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: squared magnitude, optionally blanking odd arrival indices.
  function automatic longint model(input int idx, input int re, input int im);
    longint v;
    v = longint'(re) * re + longint'(im) * im;
`ifdef FFT_MAG_NEG_BLANK_EN
    if (idx % 2 == 1) v = 0;
`endif
    return v;
  endfunction

  // pat: 0 ramp re=n im=0, 1 random with extreme first bins, 2 re=im=1
  task automatic send_frame(input int len, input int last_idx, input int pat, input bit sparse);
    int i = 0;
    int cyc = 0;
    int re, im;
    bit good = (len == NSAMPLES) && (last_idx == NSAMPLES - 1);
    while (i < len) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20 * NSAMPLES) begin
        check("send_timeout", i, len);
        break;
      end
      if (sparse && cyc[0]) begin
        bus.fft_valid = 1'b0;
        continue;
      end
      case (pat)
        0:       begin re = i; im = 0; end
        1: begin
          if (i == 0)      begin re = -32768; im = -32768; end
          else if (i == 1) begin re = 32767;  im = -32768; end
          else begin
            re = int'($urandom_range(0, 65535)) - 32768;
            im = int'($urandom_range(0, 65535)) - 32768;
          end
        end
        default: begin re = 1; im = 1; end
      endcase
      bus.fft_re    = sample_t'(re);
      bus.fft_im    = sample_t'(im);
      bus.fft_valid = 1'b1;
      bus.fft_last  = (i == last_idx);
      if (bus.fft_ready) begin
        if (good) exp_mag[i] = model(i, re, im);
        i++;
      end
    end
    @(negedge clk);
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;
  endtask

  // Collect one drained frame; abort_at >= 0 asserts reset after that output index.
  task automatic collect_frame(input string name, input int abort_at);
    int cyc = 0;
    int err0 = err_cycles;
    while (!mag_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (!mag_valid) begin
      check({name, "_start_timeout"}, 0, 1);
      return;
    end
    for (int i = 0; i < NSAMPLES; i++) begin
      check({name, "_mag_valid"}, longint'(mag_valid), 1);
      check({name, "_mag"}, longint'(mag), exp_mag[i]);
      if (i < NSAMPLES - 1) check({name, "_ready_low"}, longint'(bus.fft_ready), 0);
      if (i == abort_at) begin
        bus.fft_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check({name, "_abort_mag_valid"}, longint'(mag_valid), 0);
        check({name, "_abort_mag"}, longint'(mag), 0);
        check({name, "_abort_ready"}, longint'(bus.fft_ready), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check({name, "_release_ready"}, longint'(bus.fft_ready), 1);
        check({name, "_release_mag_valid"}, longint'(mag_valid), 0);
        $display("frame %s aborted by reset after output %0d", name, i);
        return;
      end
      // Junk traffic while not ready must be ignored.
      if (i < NSAMPLES - 4) begin
        bus.fft_re    = sample_t'($urandom);
        bus.fft_im    = sample_t'($urandom);
        bus.fft_last  = 1'($urandom);
        bus.fft_valid = 1'b1;
      end else begin
        bus.fft_valid = 1'b0;
        bus.fft_last  = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_end_mag_valid"}, longint'(mag_valid), 0);
    check({name, "_end_mag"}, longint'(mag), 0);
    check({name, "_end_ready"}, longint'(bus.fft_ready), 1);
    check({name, "_no_frame_err"}, err_cycles - err0, 0);
    $display("frame %s drained %0d bins", name, NSAMPLES);
  endtask

  task automatic bad_frame(input string name, input int len, input int last_idx);
    int err0 = err_cycles;
    int mv0  = mv_cycles;
    send_frame(len, last_idx, 1, 1'b0);
    repeat (10) @(negedge clk);
    check({name, "_err_pulse"}, err_cycles - err0, 1);
    check({name, "_no_output"}, mv_cycles - mv0, 0);
    check({name, "_ready"}, longint'(bus.fft_ready), 1);
    $display("frame %s rejected, frame_err cycles %0d", name, err_cycles - err0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.fft_re    = '0;
    bus.fft_im    = '0;
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", longint'(bus.fft_ready), 0);
    check("rst_mag_valid", longint'(mag_valid), 0);
    check("rst_mag", longint'(mag), 0);
    check("rst_frame_err", longint'(frame_err), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", longint'(bus.fft_ready), 1);

    send_frame(NSAMPLES, NSAMPLES - 1, 0, 1'b0);
    collect_frame("ramp", -1);

    send_frame(NSAMPLES, NSAMPLES - 1, 1, 1'b1);
    collect_frame("extreme_sparse", -1);

    bad_frame("early_last", 501, 500);
    send_frame(NSAMPLES, NSAMPLES - 1, 1, 1'b0);
    collect_frame("after_early_last", -1);

    bad_frame("missing_last", NSAMPLES, -1);
    send_frame(NSAMPLES, NSAMPLES - 1, 2, 1'b0);
    collect_frame("ones", -1);

    send_frame(NSAMPLES, NSAMPLES - 1, 1, 1'b0);
    collect_frame("reset_abort", 300);

    send_frame(NSAMPLES, NSAMPLES - 1, 2, 1'b1);
    collect_frame("after_reset", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_mag_streamer.md
Name: fft_mag_streamer

Overview:
- Upstream feeder for the peak finder.
- Accepts one FFT frame of complex bins through a valid/ready handshake, in bit-reversed arrival order.
- Computes the squared magnitude of each bin and buffers the whole frame.
- Replays the frame as a gap-free mag/mag_valid stream of exactly NSamples cycles, which is the contiguous window the peak finder requires.

Parameters:
- NSamples, 1024: bins per FFT frame.
- DW, 16: width of each signed real/imag component.
- W, 2*DW+1 (33): magnitude width.
- NBits, $clog2(NSamples): counter/address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- fft_re  in  DW  signed real part
- fft_im  in  DW  signed imaginary part
- fft_valid  in  1  input sample valid
- fft_last  in  1  marks final sample of frame
- fft_ready  out  1  block can accept a sample
- mag  out  W  unsigned re^2+im^2
- mag_valid  out  1  high for exactly NSamples consecutive cycles per frame
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=FILL; all counters 0; pipeline cleared.
  - Outputs: fft_ready=0, mag=0, mag_valid=0, frame_err=0.
  - fft_ready rises on the first edge after reset_n returns high.
- Arithmetic:
  - mag = re*re + im*im, signed multiplies, unsigned W-bit sum, no truncation.
  - Maximum value is 2^31 (re=im=-32768).
- Pipeline (sub-module): stage 1 registers both squares; stage 2 registers the sum and writes the buffer. Accept to buffer write = 2 cycles.
- Buffer: NSamples x W single-port-write / registered-read RAM. Address = accept order; no reordering is done.
- FILL state:
  - fft_ready=1; a sample is accepted when fft_valid && fft_ready.
  - acc_cnt increments per accept.
  - Accept with fft_last=1 and acc_cnt==NSamples-1: the frame is good. fft_ready=0 next cycle; go to FLUSH.
  - Framing error: fft_last=1 with acc_cnt<NSamples-1, or acc_cnt==NSamples-1 with fft_last=0.
    - frame_err pulses the next cycle; acc_cnt returns to 0; stay in FILL.
    - Partial data is discarded; any in-flight pipeline writes are harmless.
  - fft_valid gaps are allowed in FILL.
- FLUSH state:
  - fft_ready=0; wait until the write count reaches NSamples (2 cycles); then go to DRAIN.
- DRAIN state:
  - fft_ready=0; rd_cnt runs 0..NSamples-1, one per cycle.
  - mag/mag_valid are registered; first mag_valid comes 1 cycle after DRAIN entry.
  - mag_valid stays high for exactly NSamples consecutive cycles, with mag equal to buffer[n] in arrival order.
  - After the last output: mag_valid=0 and mag=0 next cycle; state=FILL; fft_ready=1.
- Frame gap: between drained frames mag_valid is low for at least NSamples+2 cycles, because the refill takes that long.
- Reset mid-operation: mag_valid drops on the next edge, so the downstream peak finder aborts its window. No partial frame is replayed.
- fft_last/fft_valid while fft_ready=0 are ignored.

Optional Feature:
- Macro: FFT_MAG_NEG_BLANK_EN.
- Defined: the sample at arrival index i with i[0]==1 is written as 0. Its bit-reversed k has MSB=1, i.e. a negative-frequency bin. Stream length and timing are unchanged.
- Undefined: all bins are written with their true magnitude.

Decomposition:
- Package fft_pkg:
  - constants NSAMPLES, DW, MAG_W, NBITS
  - typedefs mag_t (logic [MAG_W-1:0]) and sample_t (logic signed [DW-1:0])
  - enum state_t {FILL, FLUSH, DRAIN}
- Sub-module fft_mag_sq: 2-stage pipelined squared-magnitude unit with a valid sideband. The top level holds the FSM, counters, buffer and output registers.

Test Plan:
- Frame with re=n, im=0, n=0..1023, fft_last at n=1023 -> mag_valid high 1024 contiguous cycles; mag[n]=n^2 (mag[1023]=1046529); then fft_ready=1.
- Samples (re,im)=(-32768,-32768) and (32767,-32768) -> mag=2147483648 and 2147418113; no overflow.
- fft_last at sample 500 -> frame_err one-cycle pulse, no mag_valid. A following correct 1024-sample frame streams normally.
- fft_valid asserted every other cycle during FILL -> output is still 1024 contiguous mag_valid cycles; fft_ready=0 throughout FLUSH/DRAIN.
- reset_n low during DRAIN at rd_cnt=300 -> mag_valid=0 next edge; fft_ready=1 one cycle after release; next frame correct.
- With FFT_MAG_NEG_BLANK_EN, re=1, im=1 for all bins -> mag alternates 2,0,2,0...; without the macro -> all 2.
